ul_rx_controller: RTL and testbench

Uplink receive controller, the far-end counterpart of the downlink transmit path (training preamble followed by serialized packet).
- Monitors the serial line and its enable, and locks bit timing to the enable edge using the shared clock divider.
- Checks the alternating training preamble, then deserializes a width×depth packet into a parallel array for the downstream unscramble/decoder stage.
- Flags preamble mismatches and link drops.

---
 rtl/ul_rx_controller_pkg.sv | 22 ++
 rtl/ul_rx_controller_if.sv | 25 ++
 rtl/ul_bit_sampler.sv | 31 +++
 rtl/ul_rx_controller.sv | 158 +++++++++++++++
 tb/tb_ul_rx_controller.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/ul_rx_controller_pkg.sv
// Shared types and constants for the uplink receive controller.
package ul_rx_controller_pkg;

  localparam int unsigned DL_PREAMBLE_COUNT = 8;
  // The uplink receiver must agree with the downlink transmitter's preamble length.
  localparam int unsigned UL_PREAMBLE_COUNT = DL_PREAMBLE_COUNT;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_DATA,
    S_DONE,
    S_WAIT_IDLE
  } ul_rx_state_t;

  typedef enum logic [1:0] {
    NONE     = 2'd0,
    PREAMBLE = 2'd1,
    DROP     = 2'd2
  } ul_rx_err_t;

endpackage

// File: rtl/ul_rx_controller_if.sv
// Serial line input plus received-packet output bundle for the uplink receiver.
interface ul_rx_controller_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DATA_DEPTH = 8
);

  logic                                  ul_in;
  logic                                  ul_en;
  logic [DATA_DEPTH-1:0][DATA_WIDTH-1:0] rx_data;
  logic                                  rx_valid;
  logic                                  rx_busy;
  logic                                  rx_err;
  logic [1:0]                            rx_err_code;

  modport master (
    output ul_in, ul_en,
    input  rx_data, rx_valid, rx_busy, rx_err, rx_err_code
  );

  modport slave (
    input  ul_in, ul_en,
    output rx_data, rx_valid, rx_busy, rx_err, rx_err_code
  );

endinterface

// File: rtl/ul_bit_sampler.sv
// Bit-period phase counter; strobes once per bit at the middle of the period.
module ul_bit_sampler #(
  parameter int unsigned DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic [DIV_WIDTH-1:0] clk_div,
  output logic                 strobe
);

  logic [DIV_WIDTH-1:0] phase_q, phase_d;

  always_comb begin
    phase_d = phase_q + 1'b1;
    if (clear || phase_q >= clk_div) begin
      phase_d = '0;
    end
  end

  assign strobe = !clear && (phase_q == (clk_div >> 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/ul_rx_controller.sv
// Uplink receiver: locks to ul_en, checks the alternating preamble, deserializes the packet.
module ul_rx_controller
  import ul_rx_controller_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned DATA_DEPTH     = 8,
  parameter int unsigned DIV_WIDTH      = 8,
  parameter int unsigned PREAMBLE_COUNT = UL_PREAMBLE_COUNT
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [DIV_WIDTH-1:0]            clk_div,
  input  logic [$clog2(DATA_WIDTH):0]     width,
  input  logic [$clog2(DATA_DEPTH):0]     depth,
  ul_rx_controller_if.slave               bus
);

  localparam int unsigned WW  = $clog2(DATA_WIDTH);
  localparam int unsigned WIN = WW + 1;
  localparam int unsigned RW  = $clog2(DATA_DEPTH);
  localparam int unsigned RIN = RW + 1;
  localparam int unsigned PCW = ($clog2(PREAMBLE_COUNT) > 0) ? $clog2(PREAMBLE_COUNT) : 1;

  ul_rx_state_t                          state_q, state_d;
  ul_rx_err_t                            err_code_q, err_code_d;
  logic                                  err_q, err_d;
  logic [DIV_WIDTH-1:0]                  div_q, div_d;
  logic [WW-1:0]                         width_q, width_d, col_q, col_d;
  logic [RW-1:0]                         depth_q, depth_d, row_q, row_d;
  logic [PCW-1:0]                        pre_cnt_q, pre_cnt_d;
  logic [DATA_DEPTH-1:0][DATA_WIDTH-1:0] rx_data_q, rx_data_d;

  logic [DIV_WIDTH-1:0] div_eff;
  logic [WW-1:0]        width_eff;
  logic [RW-1:0]        depth_eff;
  logic                 sampling;
  logic                 strobe;

  assign div_eff   = (clk_div == '0) ? DIV_WIDTH'(1) : clk_div;
  assign width_eff = (width > WIN'(DATA_WIDTH - 1)) ? WW'(DATA_WIDTH - 1) : width[WW-1:0];
  assign depth_eff = (depth > RIN'(DATA_DEPTH - 1)) ? RW'(DATA_DEPTH - 1) : depth[RW-1:0];
  assign sampling  = (state_q == S_PREAMBLE) || (state_q == S_DATA);

  ul_bit_sampler #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_sampler (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (!sampling),
    .clk_div(div_q),
    .strobe (strobe)
  );

  always_comb begin
    state_d    = state_q;
    err_code_d = err_code_q;
    err_d      = 1'b0;
    div_d      = div_q;
    width_d    = width_q;
    depth_d    = depth_q;
    col_d      = col_q;
    row_d      = row_q;
    pre_cnt_d  = pre_cnt_q;
    rx_data_d  = rx_data_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.ul_en) begin
          state_d    = S_PREAMBLE;
          rx_data_d  = '0;
          err_code_d = NONE;
          pre_cnt_d  = '0;
          div_d      = div_eff;
          width_d    = width_eff;
          depth_d    = depth_eff;
        end
      end
      S_PREAMBLE: begin
        // A drop outranks a coincident strobe.
        if (!bus.ul_en) begin
          state_d    = S_IDLE;
          err_d      = 1'b1;
          err_code_d = DROP;
        end else if (strobe) begin
          if (bus.ul_in != ~pre_cnt_q[0]) begin
            state_d    = S_WAIT_IDLE;
            err_d      = 1'b1;
            err_code_d = PREAMBLE;
          end else if (pre_cnt_q == PCW'(PREAMBLE_COUNT - 1)) begin
            state_d = S_DATA;
            row_d   = '0;
            col_d   = width_q;
          end else begin
            pre_cnt_d = pre_cnt_q + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (!bus.ul_en) begin
          state_d    = S_IDLE;
          err_d      = 1'b1;
          err_code_d = DROP;
        end else if (strobe) begin
          rx_data_d[row_q][col_q] = bus.ul_in;
          if (col_q == '0) begin
            if (row_q == depth_q) begin
              state_d = S_DONE;
            end else begin
              row_d = row_q + 1'b1;
              col_d = width_q;
            end
          end else begin
            col_d = col_q - 1'b1;
          end
        end
      end
      S_DONE: state_d = S_WAIT_IDLE;
      S_WAIT_IDLE: begin
        if (!bus.ul_en) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      err_code_q <= NONE;
      err_q      <= 1'b0;
      div_q      <= '0;
      width_q    <= '0;
      depth_q    <= '0;
      col_q      <= '0;
      row_q      <= '0;
      pre_cnt_q  <= '0;
      rx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      err_code_q <= err_code_d;
      err_q      <= err_d;
      div_q      <= div_d;
      width_q    <= width_d;
      depth_q    <= depth_d;
      col_q      <= col_d;
      row_q      <= row_d;
      pre_cnt_q  <= pre_cnt_d;
      rx_data_q  <= rx_data_d;
    end
  end

  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = (state_q == S_DONE);
  assign bus.rx_busy     = (state_q != S_IDLE);
  assign bus.rx_err      = err_q;
  assign bus.rx_err_code = err_code_q;

endmodule

// File: tb/tb_ul_rx_controller.sv
// Directed bench for ul_rx_controller: normal, error, full-size, back-to-back and reset cases.
module tb_ul_rx_controller;
  import ul_rx_controller_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] clk_div;
  logic [3:0] width;
  logic [3:0] depth;

  ul_rx_controller_if #(.DATA_WIDTH(8), .DATA_DEPTH(8)) bus ();

  ul_rx_controller #(
    .DATA_WIDTH    (8),
    .DATA_DEPTH    (8),
    .DIV_WIDTH     (8),
    .PREAMBLE_COUNT(8)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .clk_div(clk_div),
    .width  (width),
    .depth  (depth),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // cyc at a falling edge equals the index of the upcoming rising edge.
  int cyc = 0;
  int base = 0;
  int n_valid = 0;
  int n_err = 0;
  int valid_rel = -1;
  int err_rel = -1;
  int n_checks = 0;
  int n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1) begin
      n_valid = n_valid + 1;
      valid_rel = cyc - base;
    end
    if (bus.rx_err === 1'b1) begin
      n_err = n_err + 1;
      err_rel = cyc - base;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 'h%0h required 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Bit k (MSB of the n-bit field first) is driven on cycles k*p .. k*p+p-1; stops before cycle stop.
  task automatic send_bits(input logic [127:0] bits, input int n, input int p, input int stop);
    base = cyc;
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < p; j++) begin
        if (k * p + j == stop) return;
        bus.ul_en = 1'b1;
        bus.ul_in = bits[n-1-k];
        @(negedge clk);
      end
    end
  endtask

  int          v0, e0;
  logic [63:0] data64, exp4;

  initial begin
    rst_n   = 1'b0;
    bus.ul_en = 1'b0;
    bus.ul_in = 1'b0;
    clk_div = 8'd3;
    width   = 4'd3;
    depth   = 4'd1;
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(1);
    chk("reset_busy", 64'(bus.rx_busy), 64'd0);
    chk("reset_valid", 64'(bus.rx_valid), 64'd0);
    chk("reset_err", 64'(bus.rx_err), 64'd0);
    chk("reset_code", 64'(bus.rx_err_code), 64'd0);
    chk("reset_data", bus.rx_data, 64'd0);

    // Normal packet: preamble 10101010, words 1011 and 0110.
    v0 = n_valid; e0 = n_err;
    send_bits(128'h0AAB6, 16, 4, -1);
    wait_cycles(1);
    chk("norm_valid_cnt", 64'(n_valid - v0), 64'd1);
    chk("norm_valid_cycle", 64'(valid_rel), 64'd63);
    chk("norm_err_cnt", 64'(n_err - e0), 64'd0);
    chk("norm_data", bus.rx_data, 64'h0000_0000_0000_060B);
    chk("norm_code", 64'(bus.rx_err_code), 64'd0);
    chk("norm_busy_tail", 64'(bus.rx_busy), 64'd1);
    bus.ul_en = 1'b0;
    wait_cycles(2);
    chk("norm_idle", 64'(bus.rx_busy), 64'd0);

    // Preamble bit 3 flipped to 1; ul_en then held 20 more cycles.
    v0 = n_valid; e0 = n_err;
    send_bits(128'h0BAB6, 16, 4, -1);
    wait_cycles(20);
    chk("pre_err_cnt", 64'(n_err - e0), 64'd1);
    chk("pre_err_cycle", 64'(err_rel), 64'd15);
    chk("pre_code", 64'(bus.rx_err_code), 64'd1);
    chk("pre_valid_cnt", 64'(n_valid - v0), 64'd0);
    chk("pre_no_restart", 64'(dut.state_q), 64'(S_WAIT_IDLE));
    bus.ul_en = 1'b0;
    wait_cycles(2);
    chk("pre_idle", 64'(bus.rx_busy), 64'd0);
    chk("pre_code_held", 64'(bus.rx_err_code), 64'd1);

    // Drop in the data phase at cycle 45: data strobes at 34/38/42 captured 1,0,1.
    v0 = n_valid; e0 = n_err;
    send_bits(128'h0AAB6, 16, 4, 45);
    bus.ul_en = 1'b0;
    wait_cycles(1);
    chk("drop_err_pulse", 64'(bus.rx_err), 64'd1);
    chk("drop_code", 64'(bus.rx_err_code), 64'd2);
    chk("drop_state", 64'(dut.state_q), 64'(S_IDLE));
    chk("drop_partial", bus.rx_data, 64'h0A);
    wait_cycles(2);
    chk("drop_err_cycle", 64'(err_rel), 64'd46);
    chk("drop_valid_cnt", 64'(n_valid - v0), 64'd0);

    // Drop coinciding with the strobe of bit 11 (a 1): that sample must be ignored.
    send_bits(128'h0AAB6, 16, 4, 46);
    bus.ul_en = 1'b0;
    wait_cycles(1);
    chk("dropstb_err", 64'(bus.rx_err), 64'd1);
    chk("dropstb_data", bus.rx_data, 64'h0A);
    wait_cycles(2);

    // Full-size packet, clk_div 0 acts as 1; width/depth above max clamp to 7.
    clk_div = 8'd0;
    width   = 4'hF;
    depth   = 4'hC;
    data64  = {$urandom, $urandom};
    for (int r = 0; r < 8; r++) exp4[8*r +: 8] = data64[63-8*r -: 8];
    v0 = n_valid; e0 = n_err;
    send_bits({56'd0, 8'hAA, data64}, 72, 2, -1);
    wait_cycles(1);
    chk("full_valid_cnt", 64'(n_valid - v0), 64'd1);
    chk("full_valid_cycle", 64'(valid_rel), 64'd144);
    chk("full_data", bus.rx_data, exp4);
    chk("full_err_cnt", 64'(n_err - e0), 64'd0);
    bus.ul_en = 1'b0;
    wait_cycles(2);

    // Back-to-back: 3x4-bit packet, one idle cycle, then a 2x2-bit packet.
    clk_div = 8'd3;
    width   = 4'd3;
    depth   = 4'd2;
    v0 = n_valid; e0 = n_err;
    send_bits(128'h0AAFFF, 20, 4, -1);
    chk("b2b_first_data", bus.rx_data, 64'h0F0F0F);
    bus.ul_en = 1'b0;
    width = 4'd1;
    depth = 4'd1;
    wait_cycles(1);
    send_bits(128'h0AA9, 12, 4, -1);
    wait_cycles(1);
    chk("b2b_valid_cnt", 64'(n_valid - v0), 64'd2);
    chk("b2b_second_cycle", 64'(valid_rel), 64'd47);
    chk("b2b_second_data", bus.rx_data, 64'h0102);
    chk("b2b_err_cnt", 64'(n_err - e0), 64'd0);
    bus.ul_en = 1'b0;
    wait_cycles(2);

    // Reset during the data phase (partial word 1000 captured by then).
    width = 4'd3;
    depth = 4'd1;
    v0 = n_valid; e0 = n_err;
    send_bits(128'h0AAB6, 16, 4, 40);
    rst_n = 1'b0;
    bus.ul_en = 1'b0;
    wait_cycles(1);
    chk("rst_data", bus.rx_data, 64'd0);
    chk("rst_busy", 64'(bus.rx_busy), 64'd0);
    chk("rst_valid", 64'(bus.rx_valid), 64'd0);
    chk("rst_err", 64'(bus.rx_err), 64'd0);
    rst_n = 1'b1;
    wait_cycles(3);
    chk("rst_no_pulses", 64'(n_valid - v0 + n_err - e0), 64'd0);
    send_bits(128'h0AAB6, 16, 4, -1);
    wait_cycles(1);
    chk("rst_restart_valid", 64'(valid_rel), 64'd63);
    chk("rst_restart_data", bus.rx_data, 64'h060B);
    bus.ul_en = 1'b0;
    wait_cycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
